alu_issue_stage: RTL and testbench

- Decode/issue pipeline stage that sits in front of the 32-bit integer ALU.
- Decodes an RV32I instruction and produces the ALU's operand and operation encoding: DATA1, DATA2, SELECT[2:0], ROTATE.
- Adds a SUB-by-negation path and branch and writeback side-band fields.
- Registered through a 2-entry skid buffer with valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_issue_stage_if.sv | 32 +++
 rtl/rv32i_alu_decoder.sv | 98 +++++++++
 rtl/alu_issue_stage.sv | 88 ++++++++
 tb/tb_alu_issue_stage.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU issue stage (ALU select, branch, memory op, opcodes, skid states).
package alu_pkg;
    typedef enum logic [2:0] {
        SEL_ADD, SEL_SLL, SEL_SLT, SEL_SLTU, SEL_XOR, SEL_SR, SEL_OR, SEL_AND
    } alu_sel_e;
    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP
    } br_e;
    typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} mem_e;
    typedef enum logic [1:0] {EMPTY, FULL1, FULL2} skid_state_e;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    typedef struct packed {
        alu_sel_e   sel;
        logic       rotate;
        logic [4:0] rd;
        logic       wb_en;
        br_e        br;
        mem_e       mem;
        logic       illegal;
    } issue_t;
endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: upstream (decode request) and downstream (ALU issue) valid/ready bundle.
//   slave  : the issue stage (consumes in_*, produces out_* and the ALU fields)
//   master : the environment around it (upstream producer plus execute consumer)
interface alu_issue_stage_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_data1;
    logic [XLEN-1:0] alu_data2;
    logic [2:0]      alu_select;
    logic            alu_rotate;
    logic [4:0]      rd_addr;
    logic            wb_en;
    logic [2:0]      br_type;
    logic [1:0]      mem_op;
    logic            illegal;
    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_data1, alu_data2, alu_select, alu_rotate,
               rd_addr, wb_en, br_type, mem_op, illegal
    );
    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_data1, alu_data2, alu_select, alu_rotate,
               rd_addr, wb_en, br_type, mem_op, illegal
    );
endinterface

// File: rtl/rv32i_alu_decoder.sv
// rv32i_alu_decoder: combinational RV32I decode into ALU operands, select/rotate and side-band fields.
//   in : instr, pc, rs1_data, rs2_data
//   out: data1, data2 (ALU operands), fields (select, rotate, rd, wb_en, br, mem, illegal)
module rv32i_alu_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] data1,
    output logic [XLEN-1:0] data2,
    output issue_t          fields
);
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_u, neg_rs2, sh_rs2, sh_imm;
    logic            bad, shift;
    logic            unused_rs1_idx;
    assign opc     = instr[6:0];
    assign rd      = instr[11:7];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign imm_i   = XLEN'($signed(instr[31:20]));
    assign imm_s   = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_u   = XLEN'($signed({instr[31:12], 12'b0}));
    assign neg_rs2 = ~rs2_data + 1'b1;
    // shift amounts are only 5 bits; upper operand bits are forced to zero
    assign sh_rs2  = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
    assign sh_imm  = {{(XLEN-5){1'b0}}, instr[24:20]};
    assign shift   = f3 == 3'b001 || f3 == 3'b101;
    assign unused_rs1_idx = ^instr[19:15];
    always_comb begin
        data1  = rs1_data;
        data2  = rs2_data;
        fields = '0;
        fields.rd    = rd;
        fields.wb_en = 1'b1;
        bad = 1'b0;
        case (opc)
            OPC_OP: begin
                fields.sel    = alu_sel_e'(f3);
                fields.rotate = f3 == 3'b101 && f7[5];
                bad   = !(f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
                data2 = shift ? sh_rs2 : (f7[5] ? neg_rs2 : rs2_data);
            end
            OPC_OP_IMM: begin
                fields.sel    = alu_sel_e'(f3);
                fields.rotate = shift && instr[30];
                bad   = shift && f7 != 7'b0 && f7 != 7'b0100000;
                data2 = shift ? sh_imm : imm_i;
            end
            OPC_LUI: begin
                data1 = '0;
                data2 = imm_u;
            end
            OPC_AUIPC: begin
                data1 = pc;
                data2 = imm_u;
            end
            OPC_JAL, OPC_JALR: begin
                data1 = pc;
                data2 = XLEN'(4);
                fields.br = BR_JUMP;
            end
            OPC_BRANCH: begin
                // EQ/NE subtract and test zero; the ordered compares use SLT/SLTU
                fields.rd    = '0;
                fields.wb_en = 1'b0;
                fields.sel   = f3[2] ? (f3[1] ? SEL_SLTU : SEL_SLT) : SEL_ADD;
                fields.br    = f3[2] ? br_e'(f3 - 3'd1) : br_e'(f3 + 3'd1);
                data2 = f3[2] ? rs2_data : neg_rs2;
                bad   = f3[2:1] == 2'b01;
            end
            OPC_LOAD: begin
                data2 = imm_i;
                fields.mem = MEM_LOAD;
            end
            OPC_STORE: begin
                data2 = imm_s;
                fields.mem   = MEM_STORE;
                fields.rd    = '0;
                fields.wb_en = 1'b0;
            end
            default: bad = 1'b1;
        endcase
        fields.wb_en = fields.wb_en && rd != 5'd0;
        if (bad) begin
            data1  = '0;
            data2  = '0;
            fields = '0;
            fields.illegal = 1'b1;
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue stage feeding the ALU through a 2-entry skid buffer.
//   clk, resetn : clock, asynchronous active-low reset
//   bus (slave) : in_valid/in_ready + instr/pc/rs1/rs2 upstream;
//                 out_valid/out_ready + ALU operands/select/rotate and side-band downstream
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input logic              clk,
    input logic              resetn,
    alu_issue_stage_if.slave bus
);
    logic [XLEN-1:0] dec_d1, dec_d2, out_d1, out_d2, sk_d1, sk_d2;
    issue_t          dec_f, out_f, sk_f;
    skid_state_e     state;
    logic            in_ready, out_valid, take, drain;
    rv32i_alu_decoder #(.XLEN(XLEN)) u_dec (
        .instr    (bus.instr),
        .pc       (bus.pc),
        .rs1_data (bus.rs1_data),
        .rs2_data (bus.rs2_data),
        .data1    (dec_d1),
        .data2    (dec_d2),
        .fields   (dec_f)
    );
    // a dropped illegal op is still consumed, it just never enters the buffer
    assign take  = bus.in_valid && in_ready && (ILLEGAL_AS_NOP || !dec_f.illegal);
    assign drain = out_valid && bus.out_ready;
    // in_ready is a flop equal to "skid entry empty", so it never depends on out_ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_d1    <= '0;
            out_d2    <= '0;
            out_f     <= '0;
            sk_d1     <= '0;
            sk_d2     <= '0;
            sk_f      <= '0;
        end else begin
            case (state)
                EMPTY: if (take) begin
                    out_d1    <= dec_d1;
                    out_d2    <= dec_d2;
                    out_f     <= dec_f;
                    out_valid <= 1'b1;
                    state     <= FULL1;
                end
                FULL1: if (take && !drain) begin
                    sk_d1    <= dec_d1;
                    sk_d2    <= dec_d2;
                    sk_f     <= dec_f;
                    in_ready <= 1'b0;
                    state    <= FULL2;
                end else if (take) begin
                    out_d1 <= dec_d1;
                    out_d2 <= dec_d2;
                    out_f  <= dec_f;
                end else if (drain) begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
                FULL2: if (drain) begin
                    out_d1   <= sk_d1;
                    out_d2   <= sk_d2;
                    out_f    <= sk_f;
                    in_ready <= 1'b1;
                    state    <= FULL1;
                end
                default: state <= EMPTY;
            endcase
        end
    end
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.alu_data1  = out_d1;
    assign bus.alu_data2  = out_d2;
    assign bus.alu_select = out_f.sel;
    assign bus.alu_rotate = out_f.rotate;
    assign bus.rd_addr    = out_f.rd;
    assign bus.wb_en      = out_f.wb_en;
    assign bus.br_type    = out_f.br;
    assign bus.mem_op     = out_f.mem;
    assign bus.illegal    = out_f.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed vector table, skid/reset sequences and random traffic against a scoreboard model.
module tb_alu_issue_stage;
    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  sel;
        logic        rot;
        logic [4:0]  rd;
        logic        wb;
        logic [2:0]  br;
        logic [1:0]  mem;
        logic        ill;
    } exp_t;
    typedef struct {
        string       name;
        logic [31:0] instr, pc, rs1, rs2;
        exp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.XLEN(32)) bus ();
    alu_issue_stage #(.XLEN(32), .ILLEGAL_AS_NOP(1'b1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int   checks = 0, errors = 0, n_out = 0;
    exp_t sb[$];
    vec_t vq[$];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t observed();
        exp_t o;
        o.d1  = bus.alu_data1;
        o.d2  = bus.alu_data2;
        o.sel = bus.alu_select;
        o.rot = bus.alu_rotate;
        o.rd  = bus.rd_addr;
        o.wb  = bus.wb_en;
        o.br  = bus.br_type;
        o.mem = bus.mem_op;
        o.ill = bus.illegal;
        return o;
    endfunction

    // what the ALU should be told for one instruction, straight from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, pc, a, b);
        exp_t        e = '0;
        logic [6:0]  f7 = ins[31:25];
        logic [2:0]  f3 = ins[14:12];
        logic [4:0]  rd = ins[11:7];
        logic [31:0] imm_i = 32'($signed(ins[31:20]));
        logic [31:0] imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        bit          legal = 1'b1;
        bit          shift = (f3 == 3'd1 || f3 == 3'd5);
        case (ins[6:0])
            7'h33: begin
                legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.d1 = a; e.sel = f3; e.rd = rd; e.wb = 1'b1;
                e.rot = f3 == 3'd5 && f7 == 7'h20;
                e.d2 = shift ? b % 32 : (f7 == 7'h20 ? 32'd0 - b : b);
            end
            7'h13: begin
                legal = !shift || f7 == 7'h00 || f7 == 7'h20;
                e.d1 = a; e.sel = f3; e.rd = rd; e.wb = 1'b1;
                e.rot = shift && ins[30];
                e.d2 = shift ? 32'(ins[24:20]) : imm_i;
            end
            7'h37: begin e.d2 = {ins[31:12], 12'h000}; e.rd = rd; e.wb = 1'b1; end
            7'h17: begin e.d1 = pc; e.d2 = {ins[31:12], 12'h000}; e.rd = rd; e.wb = 1'b1; end
            7'h6F, 7'h67: begin e.d1 = pc; e.d2 = 32'd4; e.br = 3'd7; e.rd = rd; e.wb = 1'b1; end
            7'h63: begin
                legal = f3 != 3'd2 && f3 != 3'd3;
                e.d1 = a;
                e.d2 = f3 < 3'd4 ? 32'd0 - b : b;
                e.sel = f3 < 3'd4 ? 3'd0 : (f3 < 3'd6 ? 3'd2 : 3'd3);
                e.br = f3 == 3'd0 ? 3'd1 : f3 == 3'd1 ? 3'd2 : f3 == 3'd4 ? 3'd3 :
                       f3 == 3'd5 ? 3'd4 : f3 == 3'd6 ? 3'd5 : 3'd6;
            end
            7'h03: begin e.d1 = a; e.d2 = imm_i; e.mem = 2'd1; e.rd = rd; e.wb = 1'b1; end
            7'h23: begin e.d1 = a; e.d2 = imm_s; e.mem = 2'd2; end
            default: legal = 1'b0;
        endcase
        if (rd == 5'd0) e.wb = 1'b0;
        if (!legal) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
        logic [6:0] op, f7;
        logic [4:0] rd;
        op = $urandom_range(0, 15) == 0 ? 7'($urandom) : ops[$urandom_range(0, 8)];
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), rd, op};
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic add(input string n, input logic [31:0] i, p, a, b, d1, d2,
                       input logic [2:0] sel, input logic rot, input logic [4:0] rd,
                       input logic wb, input logic [2:0] br, input logic [1:0] mem, input logic ill);
        vec_t v;
        v.name = n; v.instr = i; v.pc = p; v.rs1 = a; v.rs2 = b;
        v.exp = '{d1, d2, sel, rot, rd, wb, br, mem, ill};
        vq.push_back(v);
    endtask

    task automatic drive(input logic [31:0] i, p, a, b);
        bus.in_valid = 1'b1;
        bus.instr    = i;
        bus.pc       = p;
        bus.rs1_data = a;
        bus.rs2_data = b;
    endtask

    // scoreboard: samples 2 time units before each rising edge
    exp_t held;
    bit   stalled = 1'b0;
    initial forever begin
        @(negedge clk);
        #3;
        if (!resetn) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) check("hold_stable", observed(), held);
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_issue: got issue %h expected none", observed());
                end else check("issue_order", observed(), sb.pop_front());
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = observed();
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data));
        end
    end

    logic [31:0] ia, ib, ic;
    int          base;

    initial begin
        bus.in_valid = 1'b0; bus.instr = '0; bus.pc = '0;
        bus.rs1_data = '0; bus.rs2_data = '0; bus.out_ready = 1'b0;
        #1 resetn = 1'b0;
        #2;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_in_ready", bus.in_ready, 1'b1);
        check("reset_data", observed(), '0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        bus.out_ready = 1'b1;

        add("sub",      32'h402081B3, 32'h0,   32'h5,        32'h7,        32'h5,        32'hFFFFFFF9, 3'd0, 1'b0, 5'd3, 1'b1, 3'd0, 2'd0, 1'b0);
        add("sub_min",  32'h402081B3, 32'h0,   32'h0,        32'h80000000, 32'h0,        32'h80000000, 3'd0, 1'b0, 5'd3, 1'b1, 3'd0, 2'd0, 1'b0);
        add("sra",      32'h4020D2B3, 32'h0,   32'h80000000, 32'h24,       32'h80000000, 32'h4,        3'd5, 1'b1, 5'd5, 1'b1, 3'd0, 2'd0, 1'b0);
        add("sll",      32'h00209233, 32'h0,   32'h3,        32'hFFFFFF21, 32'h3,        32'h1,        3'd1, 1'b0, 5'd4, 1'b1, 3'd0, 2'd0, 1'b0);
        add("srai",     32'h41F0D293, 32'h0,   32'hF0000000, 32'h0,        32'hF0000000, 32'h1F,       3'd5, 1'b1, 5'd5, 1'b1, 3'd0, 2'd0, 1'b0);
        add("srai_bad", 32'h0230D293, 32'h0,   32'h1,        32'h2,        32'h0,        32'h0,        3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b1);
        add("bltu",     32'h0020E063, 32'h0,   32'h1,        32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 3'd3, 1'b0, 5'd0, 1'b0, 3'd5, 2'd0, 1'b0);
        add("beq",      32'h00208063, 32'h0,   32'hA,        32'h3,        32'hA,        32'hFFFFFFFD, 3'd0, 1'b0, 5'd0, 1'b0, 3'd1, 2'd0, 1'b0);
        add("br_bad",   32'h0020A063, 32'h0,   32'h1,        32'h1,        32'h0,        32'h0,        3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b1);
        add("addi_x0",  32'h00000013, 32'h0,   32'h0,        32'h0,        32'h0,        32'h0,        3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b0);
        add("auipc",    32'h00001397, 32'h100, 32'h0,        32'h0,        32'h100,      32'h1000,     3'd0, 1'b0, 5'd7, 1'b1, 3'd0, 2'd0, 1'b0);
        add("lui",      32'hFFFFF0B7, 32'h0,   32'h55,       32'h0,        32'h0,        32'hFFFFF000, 3'd0, 1'b0, 5'd1, 1'b1, 3'd0, 2'd0, 1'b0);
        add("jal",      32'h000000EF, 32'h200, 32'h0,        32'h0,        32'h200,      32'h4,        3'd0, 1'b0, 5'd1, 1'b1, 3'd7, 2'd0, 1'b0);
        add("lw",       32'h0080A283, 32'h0,   32'h100,      32'h0,        32'h100,      32'h8,        3'd0, 1'b0, 5'd5, 1'b1, 3'd0, 2'd1, 1'b0);
        add("sw",       32'hFE20AE23, 32'h0,   32'h1000,     32'h9,        32'h1000,     32'hFFFFFFFC, 3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 2'd2, 1'b0);
        add("mul_bad",  32'h02208133, 32'h0,   32'h1,        32'h1,        32'h0,        32'h0,        3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b1);
        add("opc_bad",  32'h0000007F, 32'h0,   32'h1,        32'h1,        32'h0,        32'h0,        3'd0, 1'b0, 5'd0, 1'b0, 3'd0, 2'd0, 1'b1);
        foreach (vq[k]) begin
            @(negedge clk);
            drive(vq[k].instr, vq[k].pc, vq[k].rs1, vq[k].rs2);
            @(negedge clk);
            bus.in_valid = 1'b0;
            #1;
            check({vq[k].name, "_valid"}, bus.out_valid, 1'b1);
            check(vq[k].name, observed(), vq[k].exp);
        end

        // three back-to-back instructions into a stalled consumer
        @(negedge clk);
        base = n_out;
        ia = 32'h002080B3; ib = 32'h0020C133; ic = 32'h4020D1B3;
        bus.out_ready = 1'b0;
        drive(ia, 32'h0, 32'h11, 32'h22);
        @(negedge clk); #1;
        check("b2b_ready_1", bus.in_ready, 1'b1);
        check("b2b_valid_1", bus.out_valid, 1'b1);
        drive(ib, 32'h0, 32'h33, 32'h44);
        @(negedge clk); #1;
        check("b2b_ready_drop", bus.in_ready, 1'b0);
        check("b2b_hold_a", observed(), model(ia, 32'h0, 32'h11, 32'h22));
        drive(ic, 32'h0, 32'h80000000, 32'h3);
        @(negedge clk); #1;
        check("b2b_ready_still_0", bus.in_ready, 1'b0);
        check("b2b_hold_a2", observed(), model(ia, 32'h0, 32'h11, 32'h22));
        bus.out_ready = 1'b1;
        @(negedge clk); #1;
        check("b2b_b_out", observed(), model(ib, 32'h0, 32'h33, 32'h44));
        check("b2b_ready_back", bus.in_ready, 1'b1);
        @(negedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_c_out", observed(), model(ic, 32'h0, 32'h80000000, 32'h3));
        repeat (3) @(negedge clk);
        #4;
        check("b2b_count", n_out - base, 3);
        check("b2b_sb_empty", sb.size(), 0);

        // asynchronous reset while both entries are occupied
        bus.out_ready = 1'b0;
        drive(ia, 32'h0, 32'h1, 32'h2);
        @(negedge clk);
        drive(ib, 32'h0, 32'h3, 32'h4);
        @(negedge clk); #1;
        check("full2_reached", bus.in_ready, 1'b0);
        #1;
        resetn = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 1'b0);
        check("async_rst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        base = n_out;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("no_stale_issue", bus.out_valid, 1'b0);
        end
        check("no_stale_count", n_out - base, 0);

        // random traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            drive(rand_instr(), $urandom, rand_data(), rand_data());
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #4;
        check("drain_sb_empty", sb.size(), 0);
        check("drain_out_valid", bus.out_valid, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
